// File: rtl/ones_link_pkg.sv
// Shared types and helpers for the ones-counting serial link (transmit and receive sides).
package ones_link_pkg;

    localparam int ONES_TX_WIDTH = 8;
    localparam int ONES_TX_MOD   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ones_tx_state_t;

    // Even-parity bit for words up to 64 bits; callers zero-extend narrower words.
    function automatic logic parity_even(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ones_stream_tx_if.sv
// Word handshake and serial line bundle between an upstream word source and ones_stream_tx.
interface ones_stream_tx_if #(
    parameter int WIDTH = 8,
    parameter int MOD   = 4
);
    logic [WIDTH-1:0]         data_in;
    logic                     valid;
    logic                     ready;
    logic                     dout;
    logic                     dout_valid;
    logic                     mark;
    logic [$clog2(MOD)-1:0]   ones_cnt;

    modport master (
        output data_in, valid,
        input  ready, dout, dout_valid, mark, ones_cnt
    );

    modport slave (
        input  data_in, valid,
        output ready, dout, dout_valid, mark, ones_cnt
    );
endinterface

// File: rtl/ones_mod_counter.sv
// Modulo-MOD accumulator with a registered wrap pulse; shared by the link's transmit and receive sides.
module ones_mod_counter
    import ones_link_pkg::*;
#(
    parameter int MOD = ONES_TX_MOD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc_i,
    output logic                   wrap_o,
    output logic [$clog2(MOD)-1:0] count_o
);
    localparam int CW = $clog2(MOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (inc_i) begin
            if (cnt_q == CW'(MOD - 1)) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign count_o = cnt_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/ones_stream_tx.sv
// MSB-first serial transmitter with a running ones count and mark on every MOD-th one.
// Define ONES_TX_PARITY_EN to append an even-parity bit after every word.
module ones_stream_tx
    import ones_link_pkg::*;
#(
    parameter int WIDTH = ONES_TX_WIDTH,
    parameter int MOD   = ONES_TX_MOD
) (
    input  logic            clk,
    input  logic            reset,
    ones_stream_tx_if.slave bus
);
    localparam int IW = $clog2(WIDTH + 1);

    ones_tx_state_t   state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ready;
    logic             lastBit;
    logic             accept;
`ifdef ONES_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // idx_q counts bits already placed on the line, so WIDTH means the last data bit is showing.
    assign lastBit = (idx_q == IW'(WIDTH));
    assign accept  = bus.valid && ready;

    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE:   ready = 1'b1;
`ifdef ONES_TX_PARITY_EN
            PARITY: ready = 1'b1;
`else
            SHIFT:  ready = lastBit;
`endif
            default: ready = 1'b0;
        endcase
    end

    // The MSB is registered at the accepting edge itself, which keeps back-to-back words gapless.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
`ifdef ONES_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = bus.data_in << 1;
            idx_d    = IW'(1);
            dout_d   = bus.data_in[WIDTH-1];
            dvalid_d = 1'b1;
`ifdef ONES_TX_PARITY_EN
            par_d    = parity_even(64'(bus.data_in));
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (!lastBit) begin
                        dout_d   = shreg_q[WIDTH-1];
                        dvalid_d = 1'b1;
                        shreg_d  = shreg_q << 1;
                        idx_d    = idx_q + IW'(1);
                    end else begin
`ifdef ONES_TX_PARITY_EN
                        state_d  = PARITY;
                        dout_d   = par_q;
                        dvalid_d = 1'b1;
`else
                        state_d  = IDLE;
`endif
                    end
                end
`ifdef ONES_TX_PARITY_EN
                PARITY: state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
`ifdef ONES_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
`ifdef ONES_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Counter advances on the same edge that registers the bit, so mark/ones_cnt align with dout.
    ones_mod_counter #(
        .MOD(MOD)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (dvalid_d & dout_d),
        .wrap_o  (bus.mark),
        .count_o (bus.ones_cnt)
    );

    assign bus.ready      = ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dvalid_q;

endmodule

// File: tb/tb_ones_stream_tx.sv
// Directed self-checking bench for ones_stream_tx (WIDTH=8, MOD=4); parity scenario when ONES_TX_PARITY_EN is defined.
module tb_ones_stream_tx;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ones_stream_tx_if #(.WIDTH(8), .MOD(4)) bus ();

    ones_stream_tx #(
        .WIDTH(8),
        .MOD  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextSlot();
        @(posedge clk);
        #1;
    endtask

    // Offers one word and checks every slot; chain leaves the line busy for an immediate next word.
    task automatic applyStimulus(input logic [7:0] word, input logic [7:0] markMask,
                                 input logic [1:0] endCnt, input bit chain);
        checkOutput($sformatf("ready_accept_%02h", word), 32'(bus.ready), 32'd1);
        bus.data_in = word;
        bus.valid   = 1'b1;
        for (int s = 0; s < 8; s++) begin
            nextSlot();
            bus.valid = 1'b0;
            checkOutput($sformatf("dout_%02h_s%0d", word, s), 32'(bus.dout), 32'(word[7-s]));
            checkOutput($sformatf("dvalid_%02h_s%0d", word, s), 32'(bus.dout_valid), 32'd1);
            checkOutput($sformatf("mark_%02h_s%0d", word, s), 32'(bus.mark), 32'(markMask[s]));
            if (s == 6) checkOutput($sformatf("ready_%02h_s6", word), 32'(bus.ready), 32'd0);
            if (s == 7) begin
                checkOutput($sformatf("ready_%02h_last", word), 32'(bus.ready), 32'd1);
                checkOutput($sformatf("cnt_%02h_end", word), 32'(bus.ones_cnt), 32'(endCnt));
            end
        end
        if (!chain) begin
            nextSlot();
            checkOutput($sformatf("idle_dvalid_%02h", word), 32'(bus.dout_valid), 32'd0);
            checkOutput($sformatf("idle_dout_%02h", word), 32'(bus.dout), 32'd0);
            checkOutput($sformatf("idle_mark_%02h", word), 32'(bus.mark), 32'd0);
            checkOutput($sformatf("idle_ready_%02h", word), 32'(bus.ready), 32'd1);
            checkOutput($sformatf("idle_cnt_%02h", word), 32'(bus.ones_cnt), 32'(endCnt));
        end
    endtask

    initial begin
`ifdef ONES_TX_PARITY_EN
        logic [8:0] expDout;
        logic [8:0] expMark;
        int         expCnt [9];
`endif
        reset       = 1'b1;
        bus.valid   = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("rst_dout", 32'(bus.dout), 32'd0);
        checkOutput("rst_dvalid", 32'(bus.dout_valid), 32'd0);
        checkOutput("rst_mark", 32'(bus.mark), 32'd0);
        checkOutput("rst_cnt", 32'(bus.ones_cnt), 32'd0);
        reset = 1'b0;
        nextSlot();

`ifdef ONES_TX_PARITY_EN
        // 8'h07: five zeros, three ones, then parity 1 completing the fourth one.
        expDout = 9'b0_0000_1111;
        expMark = 9'b0_0000_0001;
        expCnt  = '{0, 0, 0, 0, 0, 1, 2, 3, 0};
        checkOutput("par_ready_accept", 32'(bus.ready), 32'd1);
        bus.data_in = 8'h07;
        bus.valid   = 1'b1;
        for (int s = 0; s < 9; s++) begin
            nextSlot();
            bus.valid = 1'b0;
            checkOutput($sformatf("par_dout_s%0d", s), 32'(bus.dout), 32'(expDout[8-s]));
            checkOutput($sformatf("par_dvalid_s%0d", s), 32'(bus.dout_valid), 32'd1);
            checkOutput($sformatf("par_mark_s%0d", s), 32'(bus.mark), 32'(expMark[8-s]));
            checkOutput($sformatf("par_ready_s%0d", s), 32'(bus.ready), (s == 8) ? 32'd1 : 32'd0);
            checkOutput($sformatf("par_cnt_s%0d", s), 32'(bus.ones_cnt), 32'(expCnt[s]));
        end
        nextSlot();
        checkOutput("par_idle_dvalid", 32'(bus.dout_valid), 32'd0);
        checkOutput("par_idle_ready", 32'(bus.ready), 32'd1);
`else
        // 8'hBB from 0: fourth one at slot 4, six ones leave 2; 8'hC0 follows with no gap.
        applyStimulus(8'hBB, 8'h10, 2'd2, 1'b1);
        applyStimulus(8'hC0, 8'h02, 2'd0, 1'b0);
        // Empty word never marks; 8'hFF from 0 marks at slots 3 and 7.
        applyStimulus(8'h00, 8'h00, 2'd0, 1'b1);
        applyStimulus(8'hFF, 8'h88, 2'd0, 1'b0);

        // Reset in slot 2 of 8'hFF, then 8'h40 must count from zero.
        bus.data_in = 8'hFF;
        bus.valid   = 1'b1;
        nextSlot();
        bus.valid = 1'b0;
        nextSlot();
        nextSlot();
        checkOutput("mid_pre_cnt", 32'(bus.ones_cnt), 32'd3);
        checkOutput("mid_pre_dvalid", 32'(bus.dout_valid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_dout", 32'(bus.dout), 32'd0);
        checkOutput("mid_rst_dvalid", 32'(bus.dout_valid), 32'd0);
        checkOutput("mid_rst_mark", 32'(bus.mark), 32'd0);
        checkOutput("mid_rst_cnt", 32'(bus.ones_cnt), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.ready), 32'd1);
        #1;
        reset = 1'b0;
        nextSlot();
        checkOutput("mid_dropped_dvalid", 32'(bus.dout_valid), 32'd0);
        applyStimulus(8'h40, 8'h00, 2'd1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
